freq_div_detect: RTL
====================

Name: freq_div_detect

Overview:
Receive-side companion to the team's power-of-two clock divider. It samples a divided-clock signal in the same clk domain, measures its period and high time, and recovers the 3-bit division select code (period 2^(code+1) clk cycles, 2..256). It raises locked after a stable, 50%-duty period is seen repeatedly. Used in self-check and bring-up logic to confirm divider configuration.

Parameters:
SYNC_STAGES, 2, flip-flop stages on sig_in before edge detection (min 1)
LOCK_COUNT, 2, consecutive matching valid periods required to assert locked (1..7)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  reset, synchronous, active-low
sig_in  input  1  divided-clock signal under test
sel_out  output  3  recovered select code; valid only while locked=1
locked  output  1  1 = sel_out trusted
err  output  1  one-cycle pulse on invalid period, duty error, mismatch after lock, or timeout
period  output  9  last measured rising-to-rising period in clk cycles (0 = none yet)

Behaviour:
- Reset (reset=0 at a rising clk edge): sync chain 0, prev sample 0, cnt 0, hi 0, match_cnt 0, candidate 0, state IDLE, sel_out 0, locked 0, err 0, period 0. Reset has priority over every event, including mid-measurement and while locked.
- Input path: sig_in -> SYNC_STAGES flops -> s; s_d = s delayed one cycle. rise = s & ~s_d; fall = ~s & s_d.
- cnt (9-bit): on rise cycle cnt <= 1; otherwise cnt <= cnt+1, saturating at 511. At a rise, measured P = current cnt (value before reload). On fall, hi <= cnt.
- Valid period: P in {2,4,8,...,256} AND 2*hi == P. Code = log2(P)-1.
- period output updates to P at every rise in MEASURE or LOCKED (valid or not).
- States:
  IDLE: cnt runs; first rise -> MEASURE (no period update, no err).
  MEASURE: on rise: if P valid and code == candidate and match_cnt>0, match_cnt++; if P valid otherwise, candidate <= code, match_cnt <= 1; if invalid, match_cnt <= 0, err pulse. When match_cnt (post-update) == LOCK_COUNT -> LOCKED, sel_out <= candidate, locked <= 1 (same clock).
  LOCKED: on rise: P valid and code == sel_out -> stay, no output change. Otherwise: err pulse, locked <= 0, -> MEASURE; if P valid, candidate <= code, match_cnt <= 1, else match_cnt <= 0. sel_out retains old value (don't-care while unlocked).
- Timeout: cnt reaching 511 with no rise, in MEASURE or LOCKED -> one err pulse, locked <= 0, match_cnt <= 0, -> IDLE. Saturated cnt in IDLE raises no err.
- Simultaneous rise and fall impossible (single signal). Rise on the same cycle cnt saturates: rise wins (P = 511, invalid, handled as invalid period, no separate timeout).
- err is registered, exactly one cycle high per event, never two events per cycle.
- Latency: sig_in change to rise detection = SYNC_STAGES+1 clk; locked asserts on the clock of the (LOCK_COUNT+1)th detected rise.
- All outputs registered; no combinational path from sig_in to outputs.

Test Plan:
- Reset, sig_in 50% duty with period 8 clk, LOCK_COUNT=2 -> period=8 at 2nd rise, locked=1 and sel_out=2 after 3rd rise, err never pulses.
- Sweep periods 2,4,...,256 (each locked then changed) -> sel_out 0..7 respectively; each change gives one err pulse, locked drops, relocks after 2 further periods.
- Period 12 (6 high/6 low) -> err pulse at every rise after first, period=12, locked stays 0.
- Period 16 with 4-cycle high time -> duty error: err pulses each rise, locked 0, period=16.
- Locked at period 4, then hold sig_in low -> single err pulse when cnt hits 511, locked=0, state IDLE; later 4-cycle clock relocks with sel_out=1.
- Locked at period 32, assert reset=0 for one cycle mid-high-phase -> next cycle sel_out=0, locked=0, period=0, err=0; relocks after 3 rises.

Source files
------------

// File: rtl/freq_div_detect.sv
// Measures the period and high time of a divided clock sampled in the clk domain,
// recovers the power-of-two divider select code and reports lock once it is stable.
module freq_div_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sig_in,
    output logic [2:0] sel_out,
    output logic       locked,
    output logic       err,
    output logic [8:0] period
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [2:0] LC = 3'(LOCK_COUNT);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sDly;
    logic [8:0]             r_cnt;
    logic [8:0]             r_hi;
    logic [2:0]             r_cand;
    logic [2:0]             r_match;

    logic       w_s;
    logic       w_rise;
    logic       w_fall;
    logic       w_pow2;
    logic [2:0] w_code;
    logic       w_dutyOk;
    logic       w_valid;
    logic       w_timeout;
    logic [2:0] w_nextMatch;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_sDly;
    assign w_fall = ~w_s & r_sDly;

    // At a rise r_cnt still holds the completed rise-to-rise period.
    always_comb begin
        w_pow2 = 1'b1;
        w_code = 3'd0;
        case (r_cnt)
            9'd2:    w_code = 3'd0;
            9'd4:    w_code = 3'd1;
            9'd8:    w_code = 3'd2;
            9'd16:   w_code = 3'd3;
            9'd32:   w_code = 3'd4;
            9'd64:   w_code = 3'd5;
            9'd128:  w_code = 3'd6;
            9'd256:  w_code = 3'd7;
            default: w_pow2 = 1'b0;
        endcase
    end

    assign w_dutyOk    = ({r_hi, 1'b0} == {1'b0, r_cnt});
    assign w_valid     = w_pow2 & w_dutyOk;
    assign w_timeout   = (r_cnt == 9'h1FF) & ~w_rise;
    assign w_nextMatch = ((w_code == r_cand) && (r_match != 3'd0)) ? r_match + 3'd1 : 3'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
            r_sDly <= 1'b0;
            r_cnt  <= 9'd0;
            r_hi   <= 9'd0;
        end else begin
            r_sync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sDly <= w_s;
            if (w_rise) begin
                r_cnt <= 9'd1;
            end else if (r_cnt != 9'h1FF) begin
                r_cnt <= r_cnt + 9'd1;
            end
            if (w_fall) begin
                r_hi <= r_cnt;
            end
        end
    end

    // A rise always takes precedence over timeout, so at most one err event per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cand  <= 3'd0;
            r_match <= 3'd0;
            sel_out <= 3'd0;
            locked  <= 1'b0;
            err     <= 1'b0;
            period  <= 9'd0;
        end else begin
            err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        period <= r_cnt;
                        if (w_valid) begin
                            r_cand  <= w_code;
                            r_match <= w_nextMatch;
                            if (w_nextMatch == LC) begin
                                r_state <= LOCKED;
                                sel_out <= w_code;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_match <= 3'd0;
                            err     <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        err     <= 1'b1;
                        locked  <= 1'b0;
                        r_match <= 3'd0;
                        r_state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (w_rise) begin
                        period <= r_cnt;
                        if (!(w_valid && (w_code == sel_out))) begin
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            r_state <= MEASURE;
                            if (w_valid) begin
                                r_cand  <= w_code;
                                r_match <= 3'd1;
                            end else begin
                                r_match <= 3'd0;
                            end
                        end
                    end else if (w_timeout) begin
                        err     <= 1'b1;
                        locked  <= 1'b0;
                        r_match <= 3'd0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
